// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, sequencer states and data-path opcode classifier
package fetch_unit_pkg;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_LDI = 8'h02;
  localparam logic [7:0] OP_ST  = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h04;
  localparam logic [7:0] OP_INC = 8'h05;
  localparam logic [7:0] OP_DEC = 8'h06;
  localparam logic [7:0] OP_JMP = 8'h10;
  localparam logic [7:0] OP_JMA = 8'h11;
  localparam logic [7:0] OP_CLL = 8'h12;
  localparam logic [7:0] OP_RET = 8'h13;
  localparam logic [7:0] OP_RST = 8'hFF;

  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;

  function automatic logic is_datapath_opcode(input logic [7:0] op);
    return op inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_INC, OP_DEC};
  endfunction
endpackage

// File: rtl/fetch_unit_return_stack.sv
// return_stack: return-address LIFO with synchronous push and combinational top read
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0]  sp;
  logic [W-1:0] mem [DEPTH];
  assign full  = sp == (PW+1)'(DEPTH);
  assign empty = sp == '0;
  assign top   = mem[PW'(sp - 1'b1)];
  always_ff @(posedge clk) begin
    if (rst) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst && push && !full) mem[sp[PW-1:0]] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction sequencer resolving control flow and issuing data-path ops over valid/ready
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_WIDTH  = 24,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_BITS-1:0]  rom_addr,
  input  logic [WORD_WIDTH-1:0] rom_data,
  input  logic                  acc_nz,
  output logic                  instr_valid,
  output logic [7:0]            instr_opcode,
  output logic [15:0]           instr_operand,
  input  logic                  instr_ready,
  output logic                  halted,
  output logic                  error
);
  state_t state, state_n;
  logic [ADDR_BITS-1:0] pc, pc_n, pc_inc, target, top;
  logic [7:0]  op, op_n;
  logic [15:0] opd_n;
  logic valid_n, halted_n, error_n, push, pop, full, empty;
  assign op       = rom_data[WORD_WIDTH-1 -: 8];
  assign target   = rom_data[ADDR_BITS-1:0];
  assign pc_inc   = pc + 1'b1;
  assign rom_addr = pc;
  return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_BITS)) u_stack (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(pc_inc),
    .top(top), .full(full), .empty(empty)
  );
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    valid_n  = instr_valid;
    op_n     = instr_opcode;
    opd_n    = instr_operand;
    halted_n = halted;
    error_n  = error;
    push     = 1'b0;
    pop      = 1'b0;
    case (state)
      FETCH: begin
        case (op)
          OP_NOP: pc_n = pc_inc;
          OP_JMP: pc_n = target;
          OP_JMA: pc_n = acc_nz ? target : pc_inc;
          OP_CLL: begin
            push     = !full;
            pc_n     = full ? pc : target;
            error_n  = error | full;
            halted_n = halted | full;
            state_n  = full ? HALT : FETCH;
          end
          OP_RET: begin
            pop      = !empty;
            pc_n     = empty ? pc : top;
            error_n  = error | empty;
            halted_n = halted | empty;
            state_n  = empty ? HALT : FETCH;
          end
          OP_RST: begin
            halted_n = 1'b1;
            state_n  = HALT;
          end
          default: begin
            if (is_datapath_opcode(op)) begin
              op_n    = op;
              opd_n   = rom_data[15:0];
              valid_n = 1'b1;
              pc_n    = pc_inc;
              state_n = ISSUE;
            end else begin
              error_n  = 1'b1;
              halted_n = 1'b1;
              state_n  = HALT;
            end
          end
        endcase
      end
      ISSUE: begin
        valid_n = !instr_ready;
        state_n = instr_ready ? FETCH : ISSUE;
      end
      default: halted_n = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= '0;
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      halted        <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      instr_valid   <= valid_n;
      instr_opcode  <= op_n;
      instr_operand <= opd_n;
      halted        <= halted_n;
      error         <= error_n;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against an ISA-level model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_ready = 1'b0;
  logic acc_nz, instr_valid, halted, error;
  logic [7:0]  rom_addr, instr_opcode;
  logic [23:0] rom_data;
  logic [15:0] instr_operand;
  logic [23:0] rom [256];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  fetch_unit dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data), .acc_nz(acc_nz),
    .instr_valid(instr_valid), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_ready(instr_ready), .halted(halted), .error(error)
  );
  int acc;
  int acc_init = 0;
  bit use_acc = 1'b0;
  logic rnd_nz = 1'b0;
  logic [23:0] issued [$];
  assign acc_nz = use_acc ? (acc != 0) : rnd_nz;
  always @(posedge clk) begin
    if (rst) acc <= acc_init;
    else if (instr_valid && instr_ready) begin
      issued.push_back({instr_opcode, instr_operand});
      if (instr_opcode == OP_DEC) acc <= acc - 1;
    end
  end
  logic [7:0]  m_pc;
  logic [7:0]  m_stack [$];
  bit          m_valid, m_halt, m_err;
  logic [7:0]  m_op;
  logic [15:0] m_opd;
  bit          mon = 1'b0;
  always @(posedge clk) begin
    logic [23:0] w;
    w = rom[m_pc];
    if (rst) begin
      m_pc = 8'd0; m_stack.delete(); m_valid = 0; m_halt = 0; m_err = 0; mon = 1'b1;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (m_valid) begin
      if (instr_ready) m_valid = 1'b0;
    end else begin
      case (w[23:16])
        OP_NOP: m_pc = m_pc + 8'd1;
        OP_JMP: m_pc = w[7:0];
        OP_JMA: m_pc = acc_nz ? w[7:0] : m_pc + 8'd1;
        OP_CLL: if (m_stack.size() == 4) begin m_err = 1; m_halt = 1; end
                else begin m_stack.push_back(8'(m_pc + 8'd1)); m_pc = w[7:0]; end
        OP_RET: if (m_stack.size() == 0) begin m_err = 1; m_halt = 1; end
                else m_pc = m_stack.pop_back();
        OP_RST: m_halt = 1;
        default:
          if (w[23:16] inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_INC, OP_DEC}) begin
            m_valid = 1; m_op = w[23:16]; m_opd = w[15:0]; m_pc = m_pc + 8'd1;
          end else begin
            m_err = 1; m_halt = 1;
          end
      endcase
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (mon) begin
      chk("model_rom_addr", rom_addr, m_pc);
      chk("model_valid", instr_valid, m_valid);
      chk("model_halted", halted, m_halt);
      chk("model_error", error, m_err);
      if (m_valid) begin
        chk("model_opcode", instr_opcode, m_op);
        chk("model_operand", instr_operand, m_opd);
      end
    end
  end
  function automatic logic [23:0] ins(input logic [7:0] o, input logic [15:0] d);
    return {o, d};
  endfunction
  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_RST, 16'h0);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    issued.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("halt_timeout", halted, 1);
  endtask
  logic [23:0] exp_seq [5];
  logic [7:0]  ops [12];
  int decs;
  initial begin
    fill_rom();
    do_reset();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_error", error, 0);
    chk("rst_opcode", instr_opcode, 0);
    chk("rst_operand", instr_operand, 0);
    fill_rom();
    rom[0] = ins(OP_NOP, 0); rom[1] = ins(OP_CLL, 20); rom[2] = ins(OP_RST, 0);
    rom[20] = ins(OP_LDI, 5); rom[21] = ins(OP_ST, 1); rom[22] = ins(OP_LDI, 3);
    rom[23] = ins(OP_ADD, 1); rom[24] = ins(OP_ST, 2); rom[25] = ins(OP_RET, 0);
    exp_seq = '{ins(OP_LDI, 5), ins(OP_ST, 1), ins(OP_LDI, 3), ins(OP_ADD, 1), ins(OP_ST, 2)};
    instr_ready = 1'b1;
    do_reset();
    wait_halt(100);
    chk("call_issue_count", issued.size(), 5);
    for (int i = 0; i < 5 && i < issued.size(); i++) chk("call_issue_seq", issued[i], exp_seq[i]);
    chk("call_rom_addr", rom_addr, 2);
    chk("call_error", error, 0);
    fill_rom();
    rom[0] = ins(OP_LDI, 16'h1234);
    instr_ready = 1'b0;
    do_reset();
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", instr_valid, 1);
      chk("bp_opcode", instr_opcode, OP_LDI);
      chk("bp_operand", instr_operand, 16'h1234);
      chk("bp_rom_addr", rom_addr, 1);
      cyc(1);
    end
    instr_ready = 1'b1;
    cyc(1);
    instr_ready = 1'b0;
    chk("bp_valid_drop", instr_valid, 0);
    chk("bp_accepts", issued.size(), 1);
    wait_halt(5);
    chk("bp_pc_once", rom_addr, 1);
    fill_rom();
    rom[0] = ins(OP_LDI, 16'hBEEF);
    do_reset();
    cyc(2);
    chk("midrst_valid_pre", instr_valid, 1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_error", error, 0);
    rst = 1'b0;
    fill_rom();
    rom[0] = ins(OP_DEC, 0); rom[1] = ins(OP_JMA, 0); rom[2] = ins(OP_RST, 0);
    acc_init = 3;
    use_acc = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    wait_halt(100);
    decs = 0;
    foreach (issued[i]) if (issued[i][23:16] == OP_DEC) decs++;
    chk("jma_dec_count", decs, 3);
    chk("jma_error", error, 0);
    use_acc = 1'b0;
    fill_rom();
    rom[0] = ins(OP_CLL, 0);
    do_reset();
    cyc(4);
    chk("ovf_not_yet", halted, 0);
    cyc(1);
    chk("ovf_halted", halted, 1);
    chk("ovf_error", error, 1);
    chk("ovf_rom_addr", rom_addr, 0);
    fill_rom();
    rom[0] = ins(OP_RET, 0);
    do_reset();
    cyc(1);
    chk("udf_halted", halted, 1);
    chk("udf_error", error, 1);
    fill_rom();
    rom[0] = ins(OP_JMP, 16'h01FF); rom[255] = ins(OP_NOP, 0);
    do_reset();
    cyc(1);
    chk("wrap_jmp", rom_addr, 8'hFF);
    cyc(1);
    chk("wrap_nop", rom_addr, 8'h00);
    fill_rom();
    rom[0] = ins(OP_JMP, 16'h01FF); rom[255] = ins(OP_CLL, 16'h0310); rom[16] = ins(OP_RET, 0);
    do_reset();
    cyc(2);
    chk("wrap_cll_target", rom_addr, 8'h10);
    cyc(1);
    chk("wrap_cll_ret", rom_addr, 8'h00);
    chk("wrap_cll_error", error, 0);
    fill_rom();
    rom[0] = ins(8'hEE, 16'h0042);
    do_reset();
    cyc(1);
    chk("illegal_error", error, 1);
    chk("illegal_halted", halted, 1);
    chk("illegal_valid", instr_valid, 0);
    ops = '{OP_NOP, OP_LD, OP_LDI, OP_ST, OP_ADD, OP_INC, OP_DEC, OP_JMP, OP_JMA, OP_CLL, OP_RET, 8'hEE};
    for (int ep = 0; ep < 25; ep++) begin
      fill_rom();
      for (int a = 0; a < 32; a++) begin
        int r;
        r = $urandom_range(0, 47);
        rom[a] = ins(r == 47 ? OP_RST : ops[r % 12], {8'($urandom), 8'($urandom_range(0, 31))});
      end
      do_reset();
      for (int c = 0; c < 150; c++) begin
        instr_ready = ($urandom % 4) != 0;
        rnd_nz = 1'($urandom);
        cyc(1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction sequencer that reads program memory. It drives the program ROM address and consumes the 24-bit word {opcode[23:16], operand[15:0]}.
- Resolves control flow internally: NOP, JMP, JMA, CLL, RET, RST.
- Hands every data-path instruction (LD, LDI, ST, ADD, INC, DEC) to the execute stage over a valid/ready handshake.
- Sits between rom and the execute/accumulator unit.

Parameters:
- ADDR_BITS, 8, program address width (matches ROM address width)
- WORD_WIDTH, 24, instruction word width
- STACK_DEPTH, 4, return-address stack entries (power of two)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- rom_addr  output  ADDR_BITS  program address; combinational copy of pc
- rom_data  input  WORD_WIDTH  ROM word; combinational, valid in the same cycle as rom_addr
- acc_nz  input  1  accumulator non-zero flag from execute; reflects all accepted instructions from the cycle after acceptance
- instr_valid  output  1  issued instruction is valid
- instr_opcode  output  8  issued opcode
- instr_operand  output  16  issued operand
- instr_ready  input  1  execute accepts the instruction this cycle
- halted  output  1  sequencer stopped
- error  output  1  stack fault or illegal opcode

Behaviour:
- Reset: synchronous, active-high, overrides everything including an in-progress issue. All of the following go to 0: pc, sp, instr_valid, instr_opcode, instr_operand, halted, error. State goes to FETCH; stack contents are don't-care.
- State FETCH: rom_addr=pc; decode rom_data[23:16] in the same cycle.
  - NOP: pc<=pc+1.
  - JMP: pc<=operand[ADDR_BITS-1:0].
  - JMA: if acc_nz, pc<=operand[ADDR_BITS-1:0]; else pc<=pc+1.
  - CLL: stack[sp]<=pc+1, sp<=sp+1, pc<=operand[ADDR_BITS-1:0].
  - RET: sp<=sp-1, pc<=stack[sp-1].
  - RST: go to HALT, halted<=1.
  - Data-path opcode: register opcode/operand, instr_valid<=1, pc<=pc+1, go to ISSUE.
  - Any other opcode: error<=1, go to HALT.
- State ISSUE:
  - Hold instr_valid, instr_opcode and instr_operand stable until instr_ready=1.
  - On the accepting cycle, instr_valid<=0 and return to FETCH.
  - instr_ready while instr_valid=0 is ignored.
- State HALT: no fetch; pc and sp frozen; halted=1. Only rst leaves this state.
- Latency:
  - Control-flow instruction: 1 cycle.
  - Data-path instruction: instr_valid rises 1 cycle after its fetch; next fetch is 1 cycle after acceptance. With ready held high, minimum throughput is 2 cycles per instruction.
- JMA ordering: evaluated only in FETCH, which always follows acceptance of the prior instruction. acc_nz is therefore current by then.
- Boundaries:
  - pc wraps modulo 2**ADDR_BITS, so 255+1 gives 0. A CLL at 255 pushes 0.
  - Operand bits above ADDR_BITS are ignored for jump targets.
  - CLL with sp==STACK_DEPTH (full): no push, error<=1, go to HALT.
  - RET with sp==0 (empty): error<=1, go to HALT.
  - sp is ceil(log2(STACK_DEPTH))+1 bits wide.
- error and halted are sticky until rst.

Decomposition:
- Opcode constants come from the shared instructions header; no local opcode literals.
- State encoding (FETCH, ISSUE, HALT) and the is_datapath_opcode helper belong in that shared header.
- Sub-module return_stack: push/pop, full/empty flags, synchronous write, combinational top read.

Test Plan:
- Reset mid-ISSUE: rst while instr_valid=1 and ready=0 -> next cycle instr_valid=0, pc=0, sp=0, halted=0, rom_addr=0.
- Call/return, with ROM {0:NOP, 1:CLL 20, 2:RST, 20:LDI 5, 21:ST 1, 22:LDI 3, 23:ADD 1, 24:ST 2, 25:RET} and ready=1:
  - Expected issue sequence: (LDI,5), (ST,1), (LDI,3), (ADD,1), (ST,2).
  - rom_addr after RET = 2, then halted=1, error=0.
- Backpressure: hold ready=0 for 5 cycles on LDI 0x1234 -> valid, opcode and operand are stable for all 5 cycles; exactly one acceptance; pc advances only once.
- JMA loop: ROM {0:DEC, 1:JMA 0, 2:RST}, acc_nz modelled as a counter starting at 3 -> exactly 3 DEC issues, then halted=1.
- Stack faults:
  - STACK_DEPTH=4 with recursive CLL 0 at address 0 -> 4 pushes, then error=1 and halted=1 on the 5th CLL.
  - RET at address 0 with an empty stack -> error=1 and halted=1 after 1 cycle.
- Wrap and illegal opcode:
  - JMP 0x01FF -> pc=0xFF; a NOP there -> pc=0x00.
  - Opcode 0xEE (undefined) -> error=1, halted=1, no instr_valid.
